// File: rtl/cordic_arbiter.sv
// Round-robin scheduler sharing one CORDIC engine among N_REQ requesters.
// Define CORDIC_ARB_TIMEOUT_EN to build the BUSY watchdog (TIMEOUT_CYCLES).
module cordic_arbiter #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned ID_W           = 2,
    parameter int unsigned BIT_WIDTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*BIT_WIDTH-1:0] req_target,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [ID_W-1:0]            resp_id,
    output logic [BIT_WIDTH-1:0]       resp_x,
    output logic [BIT_WIDTH-1:0]       resp_y,
    output logic                       resp_err,
    output logic                       eng_start,
    output logic [BIT_WIDTH-1:0]       eng_target,
    input  logic                       eng_done,
    input  logic [BIT_WIDTH-1:0]       eng_x,
    input  logic [BIT_WIDTH-1:0]       eng_y
);

    if (N_REQ < 2 || N_REQ > 16 || ID_W != $clog2(N_REQ) || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("cordic_arbiter: inconsistent parameters");
    end

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StBusy,
        StResp
    } state_e;

    state_e         state;
    logic [ID_W-1:0] ptr;

    logic [BIT_WIDTH-1:0] tgt_arr [N_REQ];
    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign tgt_arr[i] = req_target[i*BIT_WIDTH +: BIT_WIDTH];
    end

    // Cyclic scan starting at ptr; first valid requester wins.
    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] scan_idx;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = ptr;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
            scan_idx = (scan_idx == ID_W'(N_REQ - 1)) ? '0 : scan_idx + 1'b1;
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == StIdle && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] busy_cnt;
    logic             err_q;
    logic             timeout_hit;

    assign timeout_hit = (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign resp_err    = err_q;
`else
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            ptr        <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_x     <= '0;
            resp_y     <= '0;
            eng_start  <= 1'b0;
            eng_target <= '0;
`ifdef CORDIC_ARB_TIMEOUT_EN
            busy_cnt   <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            eng_start <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (grant_found) begin
                        eng_target <= tgt_arr[grant_idx];
                        resp_id    <= grant_idx;
                        eng_start  <= 1'b1;
                        state      <= StStart;
                    end
                end
                StStart: begin
                    // eng_done here is stale from the previous run.
                    state <= StBusy;
`ifdef CORDIC_ARB_TIMEOUT_EN
                    busy_cnt <= '0;
`endif
                end
                StBusy: begin
                    if (eng_done) begin
                        resp_x     <= eng_x;
                        resp_y     <= eng_y;
                        resp_valid <= 1'b1;
                        state      <= StResp;
`ifdef CORDIC_ARB_TIMEOUT_EN
                        err_q      <= 1'b0;
                    end else if (timeout_hit) begin
                        resp_x     <= '0;
                        resp_y     <= '0;
                        err_q      <= 1'b1;
                        resp_valid <= 1'b1;
                        state      <= StResp;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
`endif
                    end
                end
                StResp: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        ptr        <= (resp_id == ID_W'(N_REQ - 1)) ? '0 : resp_id + 1'b1;
                        state      <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready));

    a_ready_needs_valid: assert property (@(posedge clk) disable iff (!rst_n)
        (req_ready & ~req_valid) == '0);

    a_start_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        eng_start |=> !eng_start);

    a_resp_stable: assert property (@(posedge clk) disable iff (!rst_n)
        resp_valid && !resp_ready |=> resp_valid && $stable({resp_id, resp_x, resp_y, resp_err}));

    a_no_grant_in_flight: assert property (@(posedge clk) disable iff (!rst_n)
        resp_valid |-> req_ready == '0);

endmodule

// File: tb/tb_cordic_arbiter.sv
// Scoreboard bench for cordic_arbiter with a behavioural engine and round-robin model.
// Timeout expectations follow CORDIC_ARB_TIMEOUT_EN.
module tb_cordic_arbiter;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int W  = 16;
    localparam int TO = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N*W-1:0]    req_target;
    logic [N-1:0]      req_ready;
    logic              resp_valid;
    logic              resp_ready;
    logic [IW-1:0]     resp_id;
    logic [W-1:0]      resp_x;
    logic [W-1:0]      resp_y;
    logic              resp_err;
    logic              eng_start;
    logic [W-1:0]      eng_target;
    logic              eng_done = 1'b1;
    logic [W-1:0]      eng_x;
    logic [W-1:0]      eng_y;

    cordic_arbiter #(
        .N_REQ(N), .ID_W(IW), .BIT_WIDTH(W), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_target(req_target), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_x(resp_x), .resp_y(resp_y), .resp_err(resp_err),
        .eng_start(eng_start), .eng_target(eng_target), .eng_done(eng_done),
        .eng_x(eng_x), .eng_y(eng_y)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] fx(input logic [W-1:0] t);
        return (t == 16'h2000) ? 16'h5A82 : (t ^ 16'h3C5A);
    endfunction
    function automatic logic [W-1:0] fy(input logic [W-1:0] t);
        return (t == 16'h2000) ? 16'h5A82 : (t + 16'h0777);
    endfunction

    // Engine model: done becomes visible k cycles after the start pulse; not reset by rst_n.
    int unsigned eng_k = 16;
    bit          eng_hang = 1'b0;
    int unsigned eng_rem = 0;
    logic [W-1:0] eng_tgt_q = '0;

    always @(posedge clk) begin
        if (eng_start) begin
            eng_tgt_q <= eng_target;
            eng_rem   <= eng_k - 1;
            eng_done  <= !eng_hang && (eng_k <= 1);
        end else if (!eng_hang && eng_rem > 0) begin
            eng_rem  <= eng_rem - 1;
            eng_done <= (eng_rem == 1);
        end
    end
    assign eng_x = eng_done ? fx(eng_tgt_q) : 16'hDEAD;
    assign eng_y = eng_done ? fy(eng_tgt_q) : 16'hBEEF;

    // Reference model: one transaction in flight, round-robin pointer.
    typedef struct packed {
        logic [IW-1:0] id;
        logic [W-1:0]  x;
        logic [W-1:0]  y;
        logic          err;
    } exp_t;

    exp_t         exp_q[$];
    int           ptr_m = 0;
    bit           start_due = 1'b0;
    logic [W-1:0] start_tgt = '0;
    int           n_resp = 0;

    always @(negedge clk) begin : grant_mon
        logic [N-1:0] exp_rdy;
        int           g;
        logic [W-1:0] t;
        exp_t         e;
        if (rst_n) begin
            exp_rdy = '0;
            g = -1;
            if (exp_q.size() == 0) begin
                for (int o = 0; o < N; o++) begin
                    if (g < 0 && req_valid[(ptr_m + o) % N]) g = (ptr_m + o) % N;
                end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("req_ready", req_ready, exp_rdy);
            check("eng_start", eng_start, start_due);
            if (start_due) check("eng_target", eng_target, start_tgt);
            start_due = 1'b0;
            if (g >= 0) begin
                t         = req_target[g*W +: W];
                start_due = 1'b1;
                start_tgt = t;
                e.id      = IW'(g);
                e.x       = eng_hang ? '0 : fx(t);
                e.y       = eng_hang ? '0 : fy(t);
                e.err     = eng_hang;
                exp_q.push_back(e);
            end
        end
    end

    always begin : resp_mon
        exp_t e;
        @(negedge clk);
        #1;
        if (rst_n && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", resp_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("resp_id", resp_id, e.id);
                check("resp_x", resp_x, e.x);
                check("resp_y", resp_y, e.y);
                check("resp_err", resp_err, e.err);
                ptr_m = (int'(e.id) + 1) % N;
                n_resp++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic drv;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic do_reset_assert;
        rst_n = 1'b0;
        exp_q.delete();
        ptr_m     = 0;
        start_due = 1'b0;
    endtask

    int          grant_cyc;
    int          resp_cyc;
    logic [IW-1:0] r_id;
    logic [W-1:0]  r_x, r_y;
    logic          r_err;

    // Starts and ends at a drive point.
    task automatic wait_any_grant(output int idx, input bit drop);
        int           n = 0;
        logic [N-1:0] hs;
        idx = -1;
        smp;
        hs = req_valid & req_ready;
        while (hs == '0 && n < 400) begin
            drv;
            smp;
            hs = req_valid & req_ready;
            n++;
        end
        check("grant_seen", |hs, 1'b1);
        for (int i = N - 1; i >= 0; i--) if (hs[i]) idx = i;
        grant_cyc = cyc;
        drv;
        if (idx >= 0) begin
            if (drop) req_valid[idx] = 1'b0;
            else req_target[idx*W +: W] = 16'($urandom);
        end
    endtask

    task automatic wait_resp(input string nm);
        int n = 0;
        smp;
        while (!(resp_valid && resp_ready) && n < 400) begin
            drv;
            smp;
            n++;
        end
        check({nm, "_resp_seen"}, resp_valid && resp_ready, 1'b1);
        resp_cyc = cyc;
        r_id  = resp_id;
        r_x   = resp_x;
        r_y   = resp_y;
        r_err = resp_err;
        drv;
    endtask

    initial begin
        int            c0, idx, n, hi_cnt;
        int            order [5];
        logic [N-1:0]  hs;
        logic [IW-1:0] s_id;
        logic [W-1:0]  s_x, s_y;
        logic          s_err;

        order = '{0, 1, 2, 3, 0};
        rst_n = 1'b1;
        req_valid = '0;
        req_target = '0;
        resp_ready = 1'b1;
        #1 do_reset_assert();
        #1;
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_id", resp_id, 0);
        check("rst_resp_x", resp_x, 0);
        check("rst_resp_y", resp_y, 0);
        check("rst_resp_err", resp_err, 1'b0);
        check("rst_eng_start", eng_start, 1'b0);
        check("rst_eng_target", eng_target, 0);
        check("rst_req_ready", req_ready, 0);
        drv;
        drv;
        rst_n = 1'b1;

        // Single request with a 16-cycle engine run.
        eng_k = 16;
        req_target[0 +: W] = 16'h2000;
        req_valid = 4'b0001;
        smp;
        c0 = cyc;
        check("single_ready_c0", req_ready, 4'b0001);
        check("single_nostart_c0", eng_start, 1'b0);
        drv;
        req_valid = '0;
        smp;
        check("single_start_c1", eng_start, 1'b1);
        check("single_target_c1", eng_target, 16'h2000);
        drv;
        wait_resp("single");
        check("single_latency", resp_cyc - c0, 18);
        check("single_id", r_id, 0);
        check("single_x", r_x, 16'h5A82);
        check("single_y", r_y, 16'h5A82);
        check("single_err", r_err, 1'b0);

        // All four held valid from reset.
        do_reset_assert();
        eng_k = 3;
        for (int i = 0; i < N; i++) req_target[i*W +: W] = 16'($urandom);
        req_valid = 4'b1111;
        drv;
        drv;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_any_grant(idx, 1'b0);
            check("rr_order", idx, order[i]);
        end
        req_valid = '0;
        wait_resp("rr_last");

        // Fairness: after 2 is served, 3 precedes 0.
        eng_k = 4;
        req_target[2*W +: W] = 16'h1111;
        req_valid[2] = 1'b1;
        wait_any_grant(idx, 1'b1);
        check("fair_first", idx, 2);
        req_target[0 +: W]   = 16'h0A0A;
        req_target[3*W +: W] = 16'h3B3B;
        req_valid[0] = 1'b1;
        req_valid[3] = 1'b1;
        wait_any_grant(idx, 1'b1);
        check("fair_second", idx, 3);
        wait_any_grant(idx, 1'b1);
        check("fair_third", idx, 0);
        wait_resp("fair_last");

        // Backpressure in RESP with another requester waiting.
        eng_k = 2;
        resp_ready = 1'b0;
        req_target[1*W +: W] = 16'h4321;
        req_valid[1] = 1'b1;
        wait_any_grant(idx, 1'b1);
        check("bp_grant", idx, 1);
        req_target[2*W +: W] = 16'h7777;
        req_valid[2] = 1'b1;
        n = 0;
        smp;
        while (!resp_valid && n < 100) begin
            drv;
            smp;
            n++;
        end
        check("bp_resp_rise", resp_valid, 1'b1);
        s_id = resp_id;
        s_x = resp_x;
        s_y = resp_y;
        s_err = resp_err;
        for (int i = 0; i < 5; i++) begin
            drv;
            smp;
            check("bp_valid_held", resp_valid, 1'b1);
            check("bp_stable", {resp_id, resp_x, resp_y, resp_err}, {s_id, s_x, s_y, s_err});
            check("bp_no_ready", req_ready, 0);
            check("bp_no_start", eng_start, 1'b0);
        end
        drv;
        resp_ready = 1'b1;
        smp;
        check("bp_handshake", resp_valid && resp_ready, 1'b1);
        drv;
        smp;
        check("bp_next_grant", req_ready, 4'b0100);
        drv;
        req_valid[2] = 1'b0;
        wait_resp("bp_second");

        // Reset in BUSY with ptr at 3, then 1 and 3 valid: ptr back at 0 grants 1.
        eng_k = 20;
        req_target[2*W +: W] = 16'h2222;
        req_valid[2] = 1'b1;
        wait_any_grant(idx, 1'b1);
        drv;
        drv;
        #2 do_reset_assert();
        #1;
        check("midrst_resp_valid", resp_valid, 1'b0);
        check("midrst_resp_id", resp_id, 0);
        check("midrst_resp_x", resp_x, 0);
        check("midrst_resp_y", resp_y, 0);
        check("midrst_resp_err", resp_err, 1'b0);
        check("midrst_eng_start", eng_start, 1'b0);
        check("midrst_eng_target", eng_target, 0);
        check("midrst_req_ready", req_ready, 0);
        drv;
        rst_n = 1'b1;
        eng_k = 3;
        req_target[1*W +: W] = 16'h0101;
        req_target[3*W +: W] = 16'h0303;
        req_valid = 4'b1010;
        wait_any_grant(idx, 1'b1);
        check("midrst_grant", idx, 1);
        req_valid = '0;
        wait_resp("midrst");

        // Engine never finishes.
        eng_hang = 1'b1;
        req_target[0 +: W] = 16'h0F0F;
        req_valid[0] = 1'b1;
        wait_any_grant(idx, 1'b1);
        c0 = grant_cyc;
`ifdef CORDIC_ARB_TIMEOUT_EN
        wait_resp("timeout");
        check("timeout_latency", resp_cyc - c0, 66);
        check("timeout_err", r_err, 1'b1);
        check("timeout_xy", {r_x, r_y}, 0);
`else
        hi_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            smp;
            if (resp_valid) hi_cnt++;
            drv;
        end
        check("hang_no_resp", hi_cnt, 0);
        do_reset_assert();
        drv;
        drv;
        rst_n = 1'b1;
`endif
        eng_hang = 1'b0;

        // Randomized traffic against the scoreboard.
        c0 = n_resp;
        hs = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int r = 0; r < N; r++) begin
                if (hs[r]) begin
                    req_valid[r] = 1'b0;
                end else if (!req_valid[r] && $urandom_range(3) == 0) begin
                    req_valid[r] = 1'b1;
                    req_target[r*W +: W] = 16'($urandom);
                end else if (req_valid[r] && $urandom_range(63) == 0) begin
                    req_valid[r] = 1'b0;
                end
            end
            resp_ready = ($urandom_range(3) != 0);
            eng_k = $urandom_range(6, 1);
            smp;
            hs = req_valid & req_ready;
            drv;
        end
        check("random_progress", (n_resp - c0) > 50, 1'b1);

        req_valid = '0;
        resp_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            drv;
            n++;
        end
        check("drain_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
